// File: rtl/altmemddr_local_arbiter.sv
// rtl/altmemddr_local_arbiter.sv - two-master round-robin arbiter for the DDR2 HP controller local port
//
// Ports:
//   clk, reset_n                      phy_clk and async active-low reset
//   mN_address/read_req/write_req     master N request (N = 0, 1), held until mN_ready
//   mN_wdata/mN_be                    master N write data, valid the cycle after mN_wdata_req
//   mN_ready/wdata_req                master N accept and write-data strobes
//   mN_rdata/rdata_valid              read data broadcast and per-master valid
//   local_*                           controller local interface
//   tag_error                         sticky: a data return arrived with no outstanding tag

// Single-bit tag FIFO holding the id of the master that owns each outstanding transfer.
module altmemddr_local_tag_fifo #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          push_id,
  input  logic          pop,
  output logic          head,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  // A pop on an empty FIFO is ignored here; the parent flags it.
  assign pop_ok = pop & ~empty;
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end
endmodule

module altmemddr_local_arbiter #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 64,
  parameter int BE_W      = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read_req,
  input  logic              m0_write_req,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BE_W-1:0]   m0_be,
  output logic              m0_ready,
  output logic              m0_wdata_req,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rdata_valid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read_req,
  input  logic              m1_write_req,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_be,
  output logic              m1_ready,
  output logic              m1_wdata_req,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rdata_valid,
  input  logic              local_init_done,
  input  logic              local_ready,
  input  logic              local_wdata_req,
  input  logic              local_rdata_valid,
  input  logic [DATA_W-1:0] local_rdata,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_read_req,
  output logic              local_write_req,
  output logic              local_burstbegin,
  output logic              local_size,
  output logic [DATA_W-1:0] local_wdata,
  output logic [BE_W-1:0]   local_be,
  output logic              tag_error
);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t            state, state_n;
  logic              last;
  logic              wsel;
  logic [ADDR_W-1:0] addr_q;

  logic              w_head, w_empty, r_head, r_empty;
  logic [CW-1:0]     w_count, r_count;
  logic              w_room, r_room;
  logic              elig0, elig1;
  logic              sel, fwd, sel_wr, accept;

  // Fullness uses the registered count, so a same-cycle pop never unmasks a request.
  assign w_room = (w_count < CW'(TAG_DEPTH));
  assign r_room = (r_count < CW'(TAG_DEPTH));

  // Write wins over read when a master raises both, so eligibility follows the write FIFO then.
  assign elig0 = local_init_done &
                 ((m0_write_req & w_room) | (m0_read_req & ~m0_write_req & r_room));
  assign elig1 = local_init_done &
                 ((m1_write_req & w_room) | (m1_read_req & ~m1_write_req & r_room));

  always_comb begin
    state_n = state;
    sel     = 1'b0;
    fwd     = 1'b0;
    case (state)
      IDLE: begin
        sel = (elig0 & elig1) ? ~last : elig1;
        fwd = elig0 | elig1;
        if (fwd && !local_ready) begin
          state_n = sel ? LOCK1 : LOCK0;
        end
      end
      LOCK0: begin
        sel = 1'b0;
        fwd = elig0;
        // Leaving on a dropped request abandons the stalled transfer without a handshake.
        if (!elig0 || local_ready) state_n = IDLE;
      end
      LOCK1: begin
        sel = 1'b1;
        fwd = elig1;
        if (!elig1 || local_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!reset_n) fwd = 1'b0;
  end

  assign sel_wr           = sel ? m1_write_req : m0_write_req;
  assign local_write_req  = fwd & sel_wr;
  assign local_read_req   = fwd & ~sel_wr;
  assign local_burstbegin = local_read_req | local_write_req;
  assign local_size       = 1'b1;
  assign local_address    = fwd ? (sel ? m1_address : m0_address) : addr_q;
  assign accept           = fwd & local_ready;
  assign m0_ready         = accept & ~sel;
  assign m1_ready         = accept & sel;

  altmemddr_local_tag_fifo #(.DEPTH(TAG_DEPTH)) u_wtag (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & local_write_req),
    .push_id (sel),
    .pop     (local_wdata_req),
    .head    (w_head),
    .empty   (w_empty),
    .count   (w_count)
  );

  altmemddr_local_tag_fifo #(.DEPTH(TAG_DEPTH)) u_rtag (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & local_read_req),
    .push_id (sel),
    .pop     (local_rdata_valid),
    .head    (r_head),
    .empty   (r_empty),
    .count   (r_count)
  );

  assign m0_wdata_req   = reset_n & local_wdata_req & ~w_empty & ~w_head;
  assign m1_wdata_req   = reset_n & local_wdata_req & ~w_empty &  w_head;
  assign m0_rdata_valid = reset_n & local_rdata_valid & ~r_empty & ~r_head;
  assign m1_rdata_valid = reset_n & local_rdata_valid & ~r_empty &  r_head;
  assign m0_rdata       = local_rdata;
  assign m1_rdata       = local_rdata;

  // Controller samples write data one cycle after local_wdata_req; wsel remembers whose it is.
  assign local_wdata = wsel ? m1_wdata : m0_wdata;
  assign local_be    = wsel ? m1_be : m0_be;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      wsel      <= 1'b0;
      addr_q    <= '0;
      tag_error <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) last <= sel;
      if (fwd) addr_q <= local_address;
      if (local_wdata_req && !w_empty) wsel <= w_head;
      if ((local_wdata_req && w_empty) || (local_rdata_valid && r_empty)) tag_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_altmemddr_local_arbiter.sv
// tb/tb_altmemddr_local_arbiter.sv - self-checking bench for altmemddr_local_arbiter
module tb_altmemddr_local_arbiter;
  localparam int ADDR_W = 23, DATA_W = 64, BE_W = 8, TAG_DEPTH = 8;
  localparam logic [63:0] D0 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] D1 = 64'h5A5A_0F0F_3C3C_9696;

  logic              clk = 1'b0, reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic              m0_read_req = 0, m0_write_req = 0, m1_read_req = 0, m1_write_req = 0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [BE_W-1:0]   m0_be = '0, m1_be = '0;
  logic              m0_ready, m0_wdata_req, m0_rdata_valid;
  logic              m1_ready, m1_wdata_req, m1_rdata_valid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              local_init_done = 0, local_ready = 0, local_wdata_req = 0, local_rdata_valid = 0;
  logic [DATA_W-1:0] local_rdata = '0;
  logic [ADDR_W-1:0] local_address;
  logic              local_read_req, local_write_req, local_burstbegin, local_size;
  logic [DATA_W-1:0] local_wdata;
  logic [BE_W-1:0]   local_be;
  logic              tag_error;

  altmemddr_local_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read_req(m0_read_req), .m0_write_req(m0_write_req),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_ready(m0_ready), .m0_wdata_req(m0_wdata_req),
    .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
    .m1_address(m1_address), .m1_read_req(m1_read_req), .m1_write_req(m1_write_req),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_ready(m1_ready), .m1_wdata_req(m1_wdata_req),
    .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
    .local_init_done(local_init_done), .local_ready(local_ready),
    .local_wdata_req(local_wdata_req), .local_rdata_valid(local_rdata_valid),
    .local_rdata(local_rdata), .local_address(local_address),
    .local_read_req(local_read_req), .local_write_req(local_write_req),
    .local_burstbegin(local_burstbegin), .local_size(local_size),
    .local_wdata(local_wdata), .local_be(local_be), .tag_error(tag_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r0, w0, r1, w1, rdy, init;
    logic e_rdy0, e_rdy1, e_lrd, e_lwr;
    logic [ADDR_W-1:0] e_addr;
  } vec_t;

  vec_t vt[13];
  int   checks = 0;
  int   errors = 0;
  int   exp_r[$];
  int   exp_w[$];

  function automatic vec_t mk(input logic r0, w0, r1, w1, rdy, init,
                              input logic e0, e1, erd, ewr, input logic [ADDR_W-1:0] ea);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.rdy = rdy; v.init = init;
    v.e_rdy0 = e0; v.e_rdy1 = e1; v.e_lrd = erd; v.e_lwr = ewr; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read_req = 0; m0_write_req = 0; m1_read_req = 0; m1_write_req = 0;
    local_ready = 0; local_init_done = 1; local_wdata_req = 0; local_rdata_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    @(negedge clk);
    next_cycle();
    reset_n = 1;
    exp_r.delete();
    exp_w.delete();
  endtask

  // Issue one cycle with the given request pattern and check the accept strobes.
  task automatic req_cycle(input string name, input logic r0, r1, rdy, input logic e0, e1);
    m0_read_req = r0; m1_read_req = r1; local_ready = rdy;
    @(negedge clk);
    chk({name, "_m0_ready"}, 64'(m0_ready), 64'(e0));
    chk({name, "_m1_ready"}, 64'(m1_ready), 64'(e1));
    if (e0) exp_r.push_back(0);
    if (e1) exp_r.push_back(1);
    next_cycle();
  endtask

  task automatic drain_reads(input int n);
    int e;
    for (int i = 0; i < n; i++) begin
      local_rdata_valid = 1;
      local_rdata = {$urandom(), $urandom()};
      @(negedge clk);
      if (exp_r.size() == 0) begin
        chk("rd_scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = exp_r.pop_front();
        chk("rd_valid_m0", 64'(m0_rdata_valid), 64'(e == 0));
        chk("rd_valid_m1", 64'(m1_rdata_valid), 64'(e == 1));
        chk("rd_data", m0_rdata, local_rdata);
      end
      next_cycle();
    end
    local_rdata_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ew;
    vt[0]  = mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 1, 23'h000123);
    vt[1]  = mk(1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 23'h020001);
    vt[2]  = mk(1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 23'h010002);
    vt[3]  = mk(1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 23'h020003);
    vt[4]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 23'h020003);
    vt[5]  = mk(0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 23'h020005);
    vt[6]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 23'h020005);
    vt[7]  = mk(1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 23'h010007);
    vt[8]  = mk(1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 23'h010008);
    vt[9]  = mk(1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 23'h010009);
    vt[10] = mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 23'h01000A);
    vt[11] = mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 23'h01000A);
    vt[12] = mk(0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 23'h02000C);

    // Outputs held low while reset is asserted, even with every input active.
    m0_write_req = 1; local_ready = 1; local_init_done = 1;
    local_wdata_req = 1; local_rdata_valid = 1;
    @(negedge clk);
    chk("rst_m0_ready", 64'(m0_ready), 64'd0);
    chk("rst_local_write_req", 64'(local_write_req), 64'd0);
    chk("rst_wdata_req", 64'({m0_wdata_req, m1_wdata_req}), 64'd0);
    chk("rst_rdata_valid", 64'({m0_rdata_valid, m1_rdata_valid}), 64'd0);
    chk("rst_tag_error", 64'(tag_error), 64'd0);
    next_cycle();
    do_reset();

    // Table of single-cycle request patterns; state carries from row to row.
    for (int i = 0; i < 13; i++) begin
      m0_read_req = vt[i].r0; m0_write_req = vt[i].w0;
      m1_read_req = vt[i].r1; m1_write_req = vt[i].w1;
      local_ready = vt[i].rdy; local_init_done = vt[i].init;
      m0_address = (i == 0) ? 23'h000123 : 23'h010000 + 23'(i);
      m1_address = 23'h020000 + 23'(i);
      @(negedge clk);
      chk($sformatf("v%0d_m0_ready", i), 64'(m0_ready), 64'(vt[i].e_rdy0));
      chk($sformatf("v%0d_m1_ready", i), 64'(m1_ready), 64'(vt[i].e_rdy1));
      chk($sformatf("v%0d_read_req", i), 64'(local_read_req), 64'(vt[i].e_lrd));
      chk($sformatf("v%0d_write_req", i), 64'(local_write_req), 64'(vt[i].e_lwr));
      chk($sformatf("v%0d_burstbegin", i), 64'(local_burstbegin), 64'(vt[i].e_lrd | vt[i].e_lwr));
      chk($sformatf("v%0d_address", i), 64'(local_address), 64'(vt[i].e_addr));
      if (vt[i].e_rdy0) begin
        if (vt[i].e_lwr) exp_w.push_back(0); else exp_r.push_back(0);
      end
      if (vt[i].e_rdy1) begin
        if (vt[i].e_lwr) exp_w.push_back(1); else exp_r.push_back(1);
      end
      next_cycle();
    end
    idle_inputs();
    chk("local_size", 64'(local_size), 64'd1);
    next_cycle();
    next_cycle();

    // Write data return: wdata_req routed by tag, data muxed one cycle later.
    m0_wdata = D0; m1_wdata = D1; m0_be = 8'h0F; m1_be = 8'hF0;
    ew = -1;
    for (int k = 0; k < 3; k++) begin
      int e;
      local_wdata_req = (k < 2);
      @(negedge clk);
      if (ew >= 0) begin
        chk("wr_local_wdata", local_wdata, (ew == 0) ? D0 : D1);
        chk("wr_local_be", 64'(local_be), (ew == 0) ? 64'h0F : 64'hF0);
      end
      ew = -1;
      if (k < 2) begin
        if (exp_w.size() == 0) begin
          chk("wr_scoreboard_empty", 64'd1, 64'd0);
        end else begin
          e = exp_w.pop_front();
          chk("wr_req_m0", 64'(m0_wdata_req), 64'(e == 0));
          chk("wr_req_m1", 64'(m1_wdata_req), 64'(e == 1));
          ew = e;
        end
      end
      next_cycle();
    end
    local_wdata_req = 0;

    // In-order read returns routed per tag.
    drain_reads(5);
    @(negedge clk);
    chk("tag_error_clean", 64'(tag_error), 64'd0);
    next_cycle();

    // Return with the read FIFO empty.
    local_rdata_valid = 1;
    @(negedge clk);
    chk("empty_pop_valid", 64'({m0_rdata_valid, m1_rdata_valid}), 64'd0);
    next_cycle();
    local_rdata_valid = 0;
    @(negedge clk);
    chk("tag_error_set", 64'(tag_error), 64'd1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("tag_error_sticky", 64'(tag_error), 64'd1);
    next_cycle();
    do_reset();
    @(negedge clk);
    chk("tag_error_cleared", 64'(tag_error), 64'd0);
    next_cycle();

    // Lock: m1 stalled three cycles while m0 also requests.
    m0_address = 23'h000AAA; m1_address = 23'h000BBB;
    req_cycle("pre", 1, 0, 1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      m0_read_req = 1; m1_read_req = 1; local_ready = 0;
      @(negedge clk);
      chk($sformatf("stall%0d_addr", c), 64'(local_address), 64'h000BBB);
      chk($sformatf("stall%0d_rd", c), 64'(local_read_req), 64'd1);
      chk($sformatf("stall%0d_ready", c), 64'({m0_ready, m1_ready}), 64'd0);
      next_cycle();
    end
    req_cycle("lock_c4", 1, 1, 1, 0, 1);
    req_cycle("lock_c5", 1, 0, 1, 1, 0);
    idle_inputs();
    drain_reads(3);
    do_reset();

    // Read tag FIFO fills at TAG_DEPTH outstanding reads.
    for (int c = 0; c < TAG_DEPTH; c++) req_cycle($sformatf("fill%0d", c), 1, 0, 1, 1, 0);
    m0_read_req = 1; local_ready = 1;
    @(negedge clk);
    chk("full_masked_ready", 64'(m0_ready), 64'd0);
    chk("full_masked_rd", 64'(local_read_req), 64'd0);
    next_cycle();
    local_rdata_valid = 1;
    @(negedge clk);
    chk("full_pop_ready", 64'(m0_ready), 64'd0);
    chk("full_pop_valid", 64'(m0_rdata_valid), 64'(exp_r.pop_front() == 0));
    next_cycle();
    local_rdata_valid = 0;
    req_cycle("full_after_pop", 1, 0, 1, 1, 0);
    idle_inputs();
    do_reset();

    // Reset with three writes outstanding.
    m0_write_req = 1; local_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("out_wr%0d", c), 64'(m0_ready), 64'd1);
      next_cycle();
    end
    local_wdata_req = 1;
    reset_n = 0;
    #1;
    chk("midrst_ready", 64'({m0_ready, m1_ready}), 64'd0);
    chk("midrst_local_req", 64'({local_write_req, local_read_req, local_burstbegin}), 64'd0);
    chk("midrst_wdata_req", 64'({m0_wdata_req, m1_wdata_req}), 64'd0);
    next_cycle();
    reset_n = 1;
    m0_write_req = 0; local_ready = 0; local_wdata_req = 1;
    @(negedge clk);
    chk("postrst_wdata_req", 64'({m0_wdata_req, m1_wdata_req}), 64'd0);
    next_cycle();
    local_wdata_req = 0;
    @(negedge clk);
    chk("postrst_tag_error", 64'(tag_error), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
